scratchpad_req_queue: RTL
=========================

SCRATCHPAD_REQ_QUEUE -- requirements
Module: scratchpad_req_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter ADDR_W, default 32, address/payload width.
REQ-003 SHALL have parameter MAT_W, default 4, matrix-register index width; NUM_MAT = 2**MAT_W.
REQ-004 SHALL define ENTRY_W = 2+MAT_W+ADDR_W; entry = {op[1:0], mat[MAT_W-1:0], payload[ADDR_W-1:0]}; op 01=load, 10=store, 11=gemm.
REQ-005 CLK  input  1  clock, rising edge.
REQ-006 RST  input  1  asynchronous, active-high reset.
REQ-007 mls_valid  input  1  matrix load/store request.
REQ-008 mls_is_load  input  1  1=load, 0=store.
REQ-009 mls_rd  input  MAT_W  matrix register.
REQ-010 mls_addr  input  ADDR_W  scratchpad address.
REQ-011 mls_ready  output  1  MLS request accepted this cycle when high with mls_valid.
REQ-012 gemm_valid  input  1  gemm request.
REQ-013 gemm_new_weight  input  1  reload-weights flag.
REQ-014 gemm_sel  input  16  gemm buffer select.
REQ-015 gemm_ready  output  1  gemm request accepted when high with gemm_valid.
REQ-016 sp_valid  output  1  head entry valid.
REQ-017 sp_data  output  ENTRY_W  head entry.
REQ-018 sp_ready  input  1  scratchpad pops head when high with sp_valid.
REQ-019 ld_done_valid, ld_done_rd  input  1, MAT_W  load completion for a matrix register.
REQ-020 flush  input  1  drop all queued entries.
REQ-021 mat_busy  output  NUM_MAT  per-register pending-load bit.
REQ-022 count  output  $clog2(DEPTH+1)  occupancy; full, empty  output  1  each.

Function
REQ-023 SHALL push at most one entry per cycle; pop at most one per cycle; push and pop in same cycle SHALL leave count unchanged.
REQ-024 MLS entry SHALL be {mls_is_load?01:10, mls_rd, mls_addr}; gemm entry SHALL be {11, gemm_new_weight,{MAT_W-1{0}}, {ADDR_W-16{0}}, gemm_sel}.
REQ-025 Eligible MLS: mls_valid && !mat_busy[mls_rd]; eligible gemm: gemm_valid.
REQ-026 Both eligible: round-robin via 1-bit last_grant register (reset = gemm, so MLS wins first); grant SHALL toggle last_grant; single eligible requester SHALL win without changing priority order beyond recording it.
REQ-027 mls_ready = eligible MLS && granted && !full && !flush; gemm_ready likewise; both depend on registered full only (no same-cycle pop bypass).
REQ-028 Pushed entry SHALL appear on sp_data no earlier than the next cycle (1-cycle latency into empty queue).
REQ-029 sp_valid = !empty; sp_data SHALL be don't-care-stable (hold last head) when empty.
REQ-030 Accepted load SHALL set mat_busy[mls_rd] at the next edge.
REQ-031 ld_done_valid SHALL clear mat_busy[ld_done_rd] at the next edge; completion for a non-busy register SHALL be ignored.
REQ-032 mat_busy used in eligibility SHALL be the registered value, so a push to a register being completed the same cycle is refused that cycle.
REQ-033 flush SHALL empty the queue next edge (count=0, pointers reset), suppress push and pop that cycle, and clear mat_busy bits of loads still queued (not yet popped); bits for already-popped loads SHALL persist.
REQ-034 Pointers SHALL wrap modulo DEPTH; full = (count==DEPTH), empty = (count==0).

Reset
REQ-035 RST high SHALL asynchronously force count=0, pointers=0, mat_busy=0, last_grant=gemm, sp_valid=0, full=0, empty=1, mls_ready=gemm_ready=0 while asserted.
REQ-036 Reset mid-operation SHALL discard all entries and pending-load state; first post-reset push SHALL land at entry 0.

Verification
REQ-037 Push MLS load rd=3 addr=0x1000, sp_ready=0 -> next cycle sp_valid=1, sp_data={01,3,0x1000}, mat_busy[3]=1, count=1.
REQ-038 Both requesters valid every cycle, sp_ready=1 -> grants alternate MLS, gemm, MLS, ...; gemm entry low 16 bits = gemm_sel.
REQ-039 Fill DEPTH=8 with sp_ready=0 -> full=1, count=8, both readys 0; then sp_ready=1 one cycle -> count=7, head advances, wrap-around order preserved over 20 pushes.
REQ-040 mat_busy[5]=1, MLS rd=5 valid with ld_done_rd=5 same cycle -> refused; next cycle busy=0, accepted.
REQ-041 Queue holds loads rd=1 (popped) and rd=2 (queued); flush -> count=0, mat_busy[2]=0, mat_busy[1]=1.
REQ-042 Assert RST with 4 entries queued -> outputs at reset values immediately; after release, push lands with count=1.

Source files
------------

// File: rtl/scratchpad_req_queue.sv
// Request queue in front of the scratchpad: arbitrates matrix load/store and gemm requests
// into one FIFO, and tracks matrix registers with an outstanding load.
module scratchpad_req_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned MAT_W  = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          mls_valid,
  input  logic                          mls_is_load,
  input  logic [MAT_W-1:0]              mls_rd,
  input  logic [ADDR_W-1:0]             mls_addr,
  output logic                          mls_ready,
  input  logic                          gemm_valid,
  input  logic                          gemm_new_weight,
  input  logic [15:0]                   gemm_sel,
  output logic                          gemm_ready,
  output logic                          sp_valid,
  output logic [2+MAT_W+ADDR_W-1:0]     sp_data,
  input  logic                          sp_ready,
  input  logic                          ld_done_valid,
  input  logic [MAT_W-1:0]              ld_done_rd,
  input  logic                          flush,
  output logic [(2**MAT_W)-1:0]         mat_busy,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          full,
  output logic                          empty
);

  localparam int unsigned ENTRY_W = 2 + MAT_W + ADDR_W;
  localparam int unsigned NUM_MAT = 2 ** MAT_W;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpStore = 2'b10;
  localparam logic [1:0] OpGemm  = 2'b11;

  typedef enum logic {GntMls = 1'b0, GntGemm = 1'b1} grant_e;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [NUM_MAT-1:0] mat_busy_q, mat_busy_d;
  grant_e             last_grant_q, last_grant_d;
  logic [ENTRY_W-1:0] hold_q, hold_d;

  logic               mls_elig, grant_mls, grant_gemm, can_push;
  logic               push, pop;
  logic [ENTRY_W-1:0] mls_entry, gemm_entry, push_data;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign sp_valid = !empty;
  assign count    = count_q;
  assign mat_busy = mat_busy_q;

  // Empty queue keeps presenting the last head instead of a stale slot.
  assign sp_data  = empty ? hold_q : mem_q[rd_ptr_q];
  assign hold_d   = sp_data;

  assign mls_entry  = {(mls_is_load ? OpLoad : OpStore), mls_rd, mls_addr};
  assign gemm_entry = {OpGemm, gemm_new_weight, {(MAT_W-1){1'b0}}, ADDR_W'(gemm_sel)};

  // Eligibility and readiness use registered state only; no same-cycle pop bypass.
  always_comb begin
    mls_elig   = mls_valid && !mat_busy_q[mls_rd];
    grant_mls  = mls_elig && (!gemm_valid || (last_grant_q == GntGemm));
    grant_gemm = gemm_valid && !grant_mls;
    can_push   = !full && !flush && !RST;
    mls_ready  = grant_mls && can_push;
    gemm_ready = grant_gemm && can_push;
    push       = mls_ready || gemm_ready;
    pop        = !empty && sp_ready && !flush;
    push_data  = mls_ready ? mls_entry : gemm_entry;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    if (mls_ready) begin
      last_grant_d = GntMls;
    end else if (gemm_ready) begin
      last_grant_d = GntGemm;
    end
  end

  // Flush releases registers whose load never left the queue; popped loads stay busy.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] offs;
    idx        = '0;
    offs       = '0;
    mat_busy_d = mat_busy_q;
    if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        idx  = PTR_W'(i);
        offs = idx - rd_ptr_q;
        if ((CNT_W'(offs) < count_q) && (mem_q[idx][ENTRY_W-1 -: 2] == OpLoad)) begin
          mat_busy_d[mem_q[idx][ADDR_W +: MAT_W]] = 1'b0;
        end
      end
    end
    if (ld_done_valid) mat_busy_d[ld_done_rd] = 1'b0;
    if (mls_ready && mls_is_load) mat_busy_d[mls_rd] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mat_busy_q   <= '0;
      last_grant_q <= GntGemm;
      hold_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mat_busy_q   <= mat_busy_d;
      last_grant_q <= last_grant_d;
      hold_q       <= hold_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
